// File: rtl/cpu_boot_seq.sv
// cpu_boot_seq: boot/run sequencer for the accumulator cpu core.
// Loads data RAM and program ROM from a byte stream, then runs the core.
//
// Ports:
//   clk, rst                 clock (rising edge), sync active-high reset
//   start                    begin load+run, honoured only when not busy
//   s_valid/s_data/s_ready   byte stream handshake
//   ram_we/ram_waddr/wdata   RAM write port, one pulse per RAM byte
//   rom_we/rom_waddr/wdata   ROM write port, one pulse per {hi,lo} word
//   cpu_rstn/cpu_setn        core reset (active low) and run enable
//   cpu_idle                 core idle flag
//   busy/done/timeout        sequencer status
//   run_cycles               RUN cycles of the last run, saturating
module cpu_boot_seq #(
  parameter int          AMSB      = 7,
  parameter int          PMSB      = 7,
  parameter int          DMSB      = 7,
  parameter int          IMSB      = 15,
  parameter int          SETUP_CYC = 2,
  parameter int          MASK_CYC  = 2,
  parameter int unsigned MAX_RUN   = 1000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            s_valid,
  input  logic [DMSB:0]   s_data,
  output logic            s_ready,
  output logic            ram_we,
  output logic [AMSB:0]   ram_waddr,
  output logic [DMSB:0]   ram_wdata,
  output logic            rom_we,
  output logic [PMSB:0]   rom_waddr,
  output logic [IMSB:0]   rom_wdata,
  output logic            cpu_rstn,
  output logic            cpu_setn,
  input  logic            cpu_idle,
  output logic            busy,
  output logic            done,
  output logic            timeout,
  output logic [31:0]     run_cycles
);

  localparam int AW = AMSB + 1;
  localparam int PW = PMSB + 1;
  localparam int IW = IMSB + 1;
  localparam int CW = 16;
  localparam int DRAIN_CYC = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LRAM,
    S_LLO,
    S_LHI,
    S_SETUP,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [AMSB:0]   addr_q, addr_d;
  logic [PMSB:0]   pc_q, pc_d;
  logic [DMSB:0]   lo_q, lo_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     run_q, run_d;
  logic            to_q, to_d;

  logic            ready_q, ready_d;
  logic            ram_we_q, ram_we_d;
  logic [AMSB:0]   ram_waddr_q, ram_waddr_d;
  logic [DMSB:0]   ram_wdata_q, ram_wdata_d;
  logic            rom_we_q, rom_we_d;
  logic [PMSB:0]   rom_waddr_q, rom_waddr_d;
  logic [IMSB:0]   rom_wdata_q, rom_wdata_d;
  logic            rstn_q, rstn_d;
  logic            setn_q, setn_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            accept;
  logic [31:0]     run_inc;
  logic            idle_hit;
  logic            to_hit;

  // ready_q always mirrors "state_q is a load state", so it is the
  // handshake qualifier as well as the registered output
  assign accept  = s_valid & ready_q;
  assign run_inc = (run_q == '1) ? run_q : run_q + 32'd1;

  // idle is masked on the first MASK_CYC RUN cycles; the timeout
  // compares against the count including the current cycle
  assign idle_hit = cpu_idle && (run_q >= 32'(MASK_CYC));
  assign to_hit   = (MAX_RUN != 0) && (run_inc == 32'(MAX_RUN));

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    pc_d        = pc_q;
    lo_d        = lo_q;
    cnt_d       = cnt_q;
    run_d       = run_q;
    to_d        = to_q;
    ram_we_d    = 1'b0;
    ram_waddr_d = ram_waddr_q;
    ram_wdata_d = ram_wdata_q;
    rom_we_d    = 1'b0;
    rom_waddr_d = rom_waddr_q;
    rom_wdata_d = rom_wdata_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_LRAM;
          addr_d  = '0;
          pc_d    = '0;
          run_d   = '0;
          to_d    = 1'b0;
        end
      end
      S_LRAM: begin
        if (accept) begin
          ram_we_d    = 1'b1;
          ram_waddr_d = addr_q;
          ram_wdata_d = s_data;
          addr_d      = addr_q + AW'(1);
          if (addr_q == '1) begin
            state_d = S_LLO;
          end
        end
      end
      S_LLO: begin
        if (accept) begin
          lo_d    = s_data;
          state_d = S_LHI;
        end
      end
      S_LHI: begin
        if (accept) begin
          rom_we_d    = 1'b1;
          rom_waddr_d = pc_q;
          rom_wdata_d = IW'({s_data, lo_q});
          pc_d        = pc_q + PW'(1);
          cnt_d       = '0;
          if (pc_q != '1) begin
            state_d = S_LLO;
          end else if (SETUP_CYC == 0) begin
            state_d = S_RUN;
          end else begin
            state_d = S_SETUP;
          end
        end
      end
      S_SETUP: begin
        if (cnt_q == CW'(SETUP_CYC - 1)) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RUN: begin
        run_d = run_inc;
        if (idle_hit) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else if (to_hit) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
          to_d    = 1'b1;
        end
      end
      S_DRAIN: begin
        if (cnt_q == CW'(DRAIN_CYC - 1)) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    endcase
  end

  // status outputs are decoded from the next state so that the
  // registered copies line up with the state they describe
  always_comb begin
    ready_d = (state_d == S_LRAM) ||
              (state_d == S_LLO)  ||
              (state_d == S_LHI);
    rstn_d  = (state_d == S_SETUP) ||
              (state_d == S_RUN)   ||
              (state_d == S_DRAIN);
    setn_d  = (state_d == S_RUN);
    busy_d  = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      pc_q        <= '0;
      lo_q        <= '0;
      cnt_q       <= '0;
      run_q       <= '0;
      to_q        <= 1'b0;
      ready_q     <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_waddr_q <= '0;
      ram_wdata_q <= '0;
      rom_we_q    <= 1'b0;
      rom_waddr_q <= '0;
      rom_wdata_q <= '0;
      rstn_q      <= 1'b0;
      setn_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      pc_q        <= pc_d;
      lo_q        <= lo_d;
      cnt_q       <= cnt_d;
      run_q       <= run_d;
      to_q        <= to_d;
      ready_q     <= ready_d;
      ram_we_q    <= ram_we_d;
      ram_waddr_q <= ram_waddr_d;
      ram_wdata_q <= ram_wdata_d;
      rom_we_q    <= rom_we_d;
      rom_waddr_q <= rom_waddr_d;
      rom_wdata_q <= rom_wdata_d;
      rstn_q      <= rstn_d;
      setn_q      <= setn_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign s_ready    = ready_q;
  assign ram_we     = ram_we_q;
  assign ram_waddr  = ram_waddr_q;
  assign ram_wdata  = ram_wdata_q;
  assign rom_we     = rom_we_q;
  assign rom_waddr  = rom_waddr_q;
  assign rom_wdata  = rom_wdata_q;
  assign cpu_rstn   = rstn_q;
  assign cpu_setn   = setn_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign timeout    = to_q;
  assign run_cycles = run_q;

endmodule

// File: tb/tb_cpu_boot_seq.sv
// tb_cpu_boot_seq: directed bench for cpu_boot_seq.
// Write scoreboard plus run-length model derived from the stop rules.
module tb_cpu_boot_seq;

  localparam int          AMSB      = 3;
  localparam int          PMSB      = 3;
  localparam int          DMSB      = 7;
  localparam int          IMSB      = 15;
  localparam int          SETUP_CYC = 2;
  localparam int          MASK_CYC  = 2;
  localparam int unsigned MAX_RUN   = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b1;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        cpu_idle = 1'b0;
  logic        s_ready;
  logic        ram_we;
  logic [3:0]  ram_waddr;
  logic [7:0]  ram_wdata;
  logic        rom_we;
  logic [3:0]  rom_waddr;
  logic [15:0] rom_wdata;
  logic        cpu_rstn;
  logic        cpu_setn;
  logic        busy;
  logic        done;
  logic        timeout;
  logic [31:0] run_cycles;

  int checks = 0;
  int errors = 0;
  int ram_cnt = 0;
  int rom_cnt = 0;
  logic [31:0] last_ram = '0;
  logic [31:0] last_rom = '0;

  typedef struct packed {
    logic [3:0]  a;
    logic [15:0] d;
  } wr_t;

  wr_t ram_exp[$];
  wr_t rom_exp[$];
  wr_t e;

  cpu_boot_seq #(
    .AMSB(AMSB), .PMSB(PMSB), .DMSB(DMSB), .IMSB(IMSB),
    .SETUP_CYC(SETUP_CYC), .MASK_CYC(MASK_CYC), .MAX_RUN(MAX_RUN)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .rom_we(rom_we), .rom_waddr(rom_waddr), .rom_wdata(rom_wdata),
    .cpu_rstn(cpu_rstn), .cpu_setn(cpu_setn), .cpu_idle(cpu_idle),
    .busy(busy), .done(done), .timeout(timeout),
    .run_cycles(run_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // cpu_idle as a function of RUN cycle index
  function automatic bit idle_pat(input int pat, input int k);
    case (pat)
      0:       return (k == 0) || (k >= 7);
      2:       return (k >= 19);
      default: return 1'b0;
    endcase
  endfunction

  // first RUN cycle that ends the run, straight from the stop rules
  task automatic model_run(input int pat, output int n, output int to);
    n  = -1;
    to = 0;
    for (int k = 0; k < 1000; k++) begin
      if (k >= MASK_CYC && idle_pat(pat, k)) begin
        n  = k + 1;
        to = 0;
        break;
      end
      if (MAX_RUN != 0 && k + 1 == int'(MAX_RUN)) begin
        n  = k + 1;
        to = 1;
        break;
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (ram_we) begin
        ram_cnt++;
        last_ram = {20'd0, ram_waddr, ram_wdata};
        if (ram_exp.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL ram_extra: write at %0h, none expected",
                   ram_waddr);
        end else begin
          e = ram_exp.pop_front();
          chk("ram_addr", 32'(ram_waddr), 32'(e.a));
          chk("ram_data", 32'(ram_wdata), 32'(e.d));
        end
      end
      if (rom_we) begin
        rom_cnt++;
        last_rom = 32'(rom_wdata);
        if (rom_exp.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rom_extra: write at %0h, none expected",
                   rom_waddr);
        end else begin
          e = rom_exp.pop_front();
          chk("rom_addr", 32'(rom_waddr), 32'(e.a));
          chk("rom_data", 32'(rom_wdata), 32'(e.d));
        end
      end
      chk("setn_needs_rstn", 32'(cpu_setn & ~cpu_rstn), 32'd0);
      chk("busy_done_excl", 32'(busy & done), 32'd0);
      chk("ready_needs_busy", 32'(s_ready & ~busy), 32'd0);
    end
  end

  task automatic chk_zero();
    chk("z_ready", 32'(s_ready), 32'd0);
    chk("z_ram_we", 32'(ram_we), 32'd0);
    chk("z_ram_waddr", 32'(ram_waddr), 32'd0);
    chk("z_ram_wdata", 32'(ram_wdata), 32'd0);
    chk("z_rom_we", 32'(rom_we), 32'd0);
    chk("z_rom_waddr", 32'(rom_waddr), 32'd0);
    chk("z_rom_wdata", 32'(rom_wdata), 32'd0);
    chk("z_rstn", 32'(cpu_rstn), 32'd0);
    chk("z_setn", 32'(cpu_setn), 32'd0);
    chk("z_busy", 32'(busy), 32'd0);
    chk("z_done", 32'(done), 32'd0);
    chk("z_timeout", 32'(timeout), 32'd0);
    chk("z_run_cycles", run_cycles, 32'd0);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n;
    if (gap) begin
      s_valid = 1'b0;
      step();
      chk("bp_ready", 32'(s_ready), 32'd1);
    end
    s_valid = 1'b1;
    s_data  = b;
    n = 0;
    while (!s_ready && n < 50) begin
      step();
      n++;
    end
    if (!s_ready) begin
      checks++;
      errors++;
      $display("FAIL send_wait: s_ready 0 after 50 cycles, need 1");
    end
    step();
    s_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_ready", 32'(s_ready), 32'd1);
    chk("start_timeout", 32'(timeout), 32'd0);
    chk("start_run_cycles", run_cycles, 32'd0);
    chk("start_done", 32'(done), 32'd0);
  endtask

  task automatic load(input logic [7:0] roff, input logic [7:0] poff,
                      input bit gaps, input int nrom);
    logic [7:0] b;
    logic [7:0] lo;
    lo = 8'h00;
    ram_cnt = 0;
    rom_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      b = 8'(i) + roff;
      ram_exp.push_back(wr_t'({4'(i), 8'h00, b}));
      send_byte(b, gaps);
    end
    for (int j = 0; j < nrom; j++) begin
      b = 8'(j) + poff;
      if (j % 2 == 0) lo = b;
      else rom_exp.push_back(wr_t'({4'(j / 2), b, lo}));
      send_byte(b, gaps);
    end
  endtask

  task automatic run_check(input int pat, input int lit_n,
                           input int lit_to, input bit poke);
    int n_exp;
    int to_exp;
    int n;
    int k;
    model_run(pat, n_exp, to_exp);
    chk("pin_run_len", n_exp, lit_n);
    chk("pin_timeout", to_exp, lit_to);
    n = 0;
    while (!cpu_setn && n < 10) begin
      chk("setup_rstn", 32'(cpu_rstn), 32'd1);
      step();
      n++;
    end
    chk("setn_latency", n + 1, SETUP_CYC + 1);
    chk("ram_writes", ram_cnt, 32'd16);
    chk("rom_writes", rom_cnt, 32'd16);
    k = 0;
    while (cpu_setn && k < 100) begin
      cpu_idle = idle_pat(pat, k);
      start = poke && (k == 3);
      chk("run_count", run_cycles, k);
      step();
      start = 1'b0;
      k++;
    end
    cpu_idle = 1'b0;
    chk("run_len", k, n_exp);
    for (int d = 0; d < 2; d++) begin
      chk("drain_rstn", 32'(cpu_rstn), 32'd1);
      chk("drain_setn", 32'(cpu_setn), 32'd0);
      chk("drain_done", 32'(done), 32'd0);
      step();
    end
    chk("end_done", 32'(done), 32'd1);
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_rstn", 32'(cpu_rstn), 32'd0);
    chk("end_setn", 32'(cpu_setn), 32'd0);
    chk("end_ready", 32'(s_ready), 32'd0);
    chk("end_run_cycles", run_cycles, n_exp);
    chk("end_timeout", 32'(timeout), to_exp);
  endtask

  initial begin
    repeat (3) step();
    chk_zero();
    rst   = 1'b0;
    start = 1'b0;
    step();
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_ready", 32'(s_ready), 32'd0);

    do_start();
    load(8'h00, 8'h00, 1'b0, 32);
    run_check(0, 8, 0, 1'b0);
    chk("lit_last_ram", last_ram, 32'h0000_0F0F);
    chk("lit_last_rom", last_rom, 32'h0000_1F1E);

    do_start();
    load(8'hA0, 8'h60, 1'b1, 32);
    run_check(1, 20, 1, 1'b0);

    do_start();
    load(8'h11, 8'hC4, 1'b0, 32);
    run_check(2, 20, 0, 1'b1);

    do_start();
    load(8'h40, 8'h80, 1'b0, 5);
    chk("abort_rom_writes", rom_cnt, 32'd2);
    rst = 1'b1;
    step();
    chk_zero();
    rst = 1'b0;
    ram_exp.delete();
    rom_exp.delete();
    step();
    chk("abort_idle_busy", 32'(busy), 32'd0);

    do_start();
    load(8'h55, 8'h33, 1'b0, 32);
    run_check(0, 8, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
